// File: rtl/modport_axi_slave.sv
// AXI4 memory-backed slave endpoint: independent write and read paths, one transaction each.
// Latency: AW/AR accepted in IDLE; B one cycle after the final W beat; R beat 0 one cycle after AR.
// Backpressure: B and R outputs hold stable while BREADY/RREADY are low. Optional feature: AXI_USER_EN.
module modport_axi_slave #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MEM_DEPTH = 256,
  parameter int STRB_W    = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   S4_AWID,
  input  logic [ADDR_W-1:0] S4_AWADDR,
  input  logic [LEN_W-1:0]  S4_AWLEN,
  input  logic [2:0]        S4_AWSIZE,
  input  logic [1:0]        S4_AWBURST,
  input  logic              S4_AWLOCK,
  input  logic [3:0]        S4_AWCACHE,
  input  logic [2:0]        S4_AWPROT,
  input  logic [3:0]        S4_AWQOS,
  input  logic [3:0]        S4_AWREGION,
  input  logic              S4_AWUSER,
  input  logic              S4_AWVALID,
  output logic              S4_AWREADY,
  input  logic [DATA_W-1:0] S4_WDATA,
  input  logic [STRB_W-1:0] S4_WSTRB,
  input  logic              S4_WLAST,
  input  logic              S4_WUSER,
  input  logic              S4_WVALID,
  output logic              S4_WREADY,
  output logic [ID_W-1:0]   S4_BID,
  output logic [1:0]        S4_BRESP,
  output logic              S4_BVALID,
  output logic              S4_BUSER,
  input  logic              S4_BREADY,
  input  logic [ID_W-1:0]   S4_ARID,
  input  logic [ADDR_W-1:0] S4_ARADDR,
  input  logic [LEN_W-1:0]  S4_ARLEN,
  input  logic [2:0]        S4_ARSIZE,
  input  logic [1:0]        S4_ARBURST,
  input  logic              S4_ARLOCK,
  input  logic [3:0]        S4_ARCACHE,
  input  logic [2:0]        S4_ARPROT,
  input  logic [3:0]        S4_ARQOS,
  input  logic [3:0]        S4_ARREGION,
  input  logic              S4_ARUSER,
  input  logic              S4_ARVALID,
  output logic              S4_ARREADY,
  output logic [ID_W-1:0]   S4_RID,
  output logic [DATA_W-1:0] S4_RDATA,
  output logic [1:0]        S4_RRESP,
  output logic              S4_RLAST,
  output logic              S4_RVALID,
  output logic              S4_RUSER,
  input  logic              S4_RREADY
);
  localparam int OFF_W = $clog2(STRB_W);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * STRB_W);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] ln);
    return (ln == LEN_W'(1)) || (ln == LEN_W'(3)) || (ln == LEN_W'(7)) || (ln == LEN_W'(15));
  endfunction

  // Size and burst errors are fixed for the whole burst.
  function automatic logic cmd_err(input logic [2:0] sz, input logic [1:0] bu, input logic [LEN_W-1:0] ln);
    return (sz > 3'(OFF_W)) || (bu == 2'b11) || ((bu == 2'b10) && !wrap_len_ok(ln));
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  // Malformed WRAP and reserved bursts fall back to INCR stepping.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                  input logic [LEN_W-1:0] ln, input logic [1:0] bu);
    logic [ADDR_W-1:0] s, win, nxt;
    s   = ADDR_W'(1) << sz;
    win = s * (ADDR_W'(ln) + ADDR_W'(1));
    nxt = a + s;
    if (bu == 2'b00) return a;
    else if ((bu == 2'b10) && wrap_len_ok(ln)) return (a & ~(win - ADDR_W'(1))) | (nxt & (win - ADDR_W'(1)));
    else return nxt;
  endfunction

  // ---------------- write path ----------------
  w_state_t w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_addr_nxt;
  logic [LEN_W-1:0]  w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, aw_rdy, w_rdy, b_vld, aw_hs, w_hs, w_final;

  assign w_final    = (w_cnt == w_len) || S4_WLAST;
  assign aw_hs      = aw_rdy && S4_AWVALID;
  assign w_hs       = w_rdy && S4_WVALID;
  assign w_addr_nxt = step_addr(w_addr, w_size, w_len, w_burst);

  // Write state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write next-state and handshake outputs; readies are masked while reset is held.
  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = !ARESET;
        if (S4_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = !ARESET;
        if (S4_WVALID && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (S4_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write command latch, beat counter and sticky error.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id <= S4_AWID; w_addr <= S4_AWADDR; w_len <= S4_AWLEN; w_cnt <= '0;
      w_size <= S4_AWSIZE; w_burst <= S4_AWBURST;
      w_err <= cmd_err(S4_AWSIZE, S4_AWBURST, S4_AWLEN);
    end else if (w_hs) begin
      w_cnt  <= w_cnt + LEN_W'(1);
      w_addr <= w_addr_nxt;
      // WLAST must coincide exactly with the final counted beat.
      if (!in_range(w_addr) || ((w_cnt == w_len) != S4_WLAST)) w_err <= 1'b1;
    end
  end

  // RAM byte-lane writes; out-of-range beats are dropped and the array is never reset.
  always_ff @(posedge ACLK) begin
    if (w_hs && in_range(w_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S4_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S4_WDATA[8*b +: 8];
      end
    end
  end

  assign S4_AWREADY = aw_rdy;
  assign S4_WREADY  = w_rdy;
  assign S4_BVALID  = b_vld;
  assign S4_BID     = w_id;
  assign S4_BRESP   = {w_err, 1'b0};

  // ---------------- read path ----------------
  r_state_t r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_addr_nxt;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst, r_resp;
  logic [DATA_W-1:0] r_data;
  logic              r_cerr, r_last, ar_rdy, r_vld, ar_hs, r_hs;

  assign ar_hs      = ar_rdy && S4_ARVALID;
  assign r_hs       = r_vld && S4_RREADY;
  assign r_addr_nxt = step_addr(r_addr, r_size, r_len, r_burst);

  // Read state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read next-state and handshake outputs.
  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    r_vld  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = !ARESET;
        if (S4_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (S4_RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read command latch and registered beat; RAM is sampled before same-edge writes land.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0;
      r_cerr <= 1'b0; r_data <= '0; r_resp <= '0; r_last <= 1'b0;
    end else if (ar_hs) begin
      r_id <= S4_ARID; r_addr <= S4_ARADDR; r_len <= S4_ARLEN; r_cnt <= '0;
      r_size <= S4_ARSIZE; r_burst <= S4_ARBURST;
      r_cerr <= cmd_err(S4_ARSIZE, S4_ARBURST, S4_ARLEN);
      r_last <= (S4_ARLEN == '0);
      r_data <= in_range(S4_ARADDR) ? mem[word_idx(S4_ARADDR)] : '0;
      r_resp <= {cmd_err(S4_ARSIZE, S4_ARBURST, S4_ARLEN) || !in_range(S4_ARADDR), 1'b0};
    end else if (r_hs && !r_last) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + LEN_W'(1);
      r_last <= (LEN_W'(r_cnt + LEN_W'(1)) == r_len);
      r_data <= in_range(r_addr_nxt) ? mem[word_idx(r_addr_nxt)] : '0;
      r_resp <= {r_cerr || !in_range(r_addr_nxt), 1'b0};
    end else if (r_hs) begin
      r_last <= 1'b0;
    end
  end

  assign S4_ARREADY = ar_rdy;
  assign S4_RVALID  = r_vld;
  assign S4_RID     = r_id;
  assign S4_RDATA   = r_data;
  assign S4_RRESP   = r_resp;
  assign S4_RLAST   = r_last;

`ifdef AXI_USER_EN
  logic b_user, r_user;
  // USER bits are captured at the address handshake and held for the whole response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      b_user <= 1'b0;
      r_user <= 1'b0;
    end else begin
      if (aw_hs) b_user <= S4_AWUSER;
      if (ar_hs) r_user <= S4_ARUSER;
    end
  end
  assign S4_BUSER = b_user;
  assign S4_RUSER = r_user;
`else
  assign S4_BUSER = 1'b0;
  assign S4_RUSER = 1'b0;
`endif

  logic unused_sideband;
  assign unused_sideband = ^{S4_AWLOCK, S4_AWCACHE, S4_AWPROT, S4_AWQOS, S4_AWREGION, S4_AWUSER, S4_WUSER,
                             S4_ARLOCK, S4_ARCACHE, S4_ARPROT, S4_ARQOS, S4_ARREGION, S4_ARUSER};
endmodule

// File: tb/tb_modport_axi_slave.sv
// Directed bench for modport_axi_slave: table of single-beat transactions plus burst sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every handshake wait is bounded by a cycle budget.
module tb_modport_axi_slave;
  logic        ACLK, ARESET;
  logic [3:0]  S4_AWID, S4_AWLEN, S4_AWCACHE, S4_AWQOS, S4_AWREGION;
  logic [31:0] S4_AWADDR;
  logic [2:0]  S4_AWSIZE, S4_AWPROT;
  logic [1:0]  S4_AWBURST;
  logic        S4_AWLOCK, S4_AWUSER, S4_AWVALID, S4_AWREADY;
  logic [31:0] S4_WDATA;
  logic [3:0]  S4_WSTRB;
  logic        S4_WLAST, S4_WUSER, S4_WVALID, S4_WREADY;
  logic [3:0]  S4_BID;
  logic [1:0]  S4_BRESP;
  logic        S4_BVALID, S4_BUSER, S4_BREADY;
  logic [3:0]  S4_ARID, S4_ARLEN, S4_ARCACHE, S4_ARQOS, S4_ARREGION;
  logic [31:0] S4_ARADDR;
  logic [2:0]  S4_ARSIZE, S4_ARPROT;
  logic [1:0]  S4_ARBURST;
  logic        S4_ARLOCK, S4_ARUSER, S4_ARVALID, S4_ARREADY;
  logic [3:0]  S4_RID;
  logic [31:0] S4_RDATA;
  logic [1:0]  S4_RRESP;
  logic        S4_RLAST, S4_RVALID, S4_RUSER, S4_RREADY;

  int checks = 0;
  int errors = 0;

`ifdef AXI_USER_EN
  localparam logic EXP_USER = 1'b1;
`else
  localparam logic EXP_USER = 1'b0;
`endif

  modport_axi_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S4_AWID(S4_AWID), .S4_AWADDR(S4_AWADDR), .S4_AWLEN(S4_AWLEN), .S4_AWSIZE(S4_AWSIZE),
    .S4_AWBURST(S4_AWBURST), .S4_AWLOCK(S4_AWLOCK), .S4_AWCACHE(S4_AWCACHE), .S4_AWPROT(S4_AWPROT),
    .S4_AWQOS(S4_AWQOS), .S4_AWREGION(S4_AWREGION), .S4_AWUSER(S4_AWUSER), .S4_AWVALID(S4_AWVALID),
    .S4_AWREADY(S4_AWREADY),
    .S4_WDATA(S4_WDATA), .S4_WSTRB(S4_WSTRB), .S4_WLAST(S4_WLAST), .S4_WUSER(S4_WUSER),
    .S4_WVALID(S4_WVALID), .S4_WREADY(S4_WREADY),
    .S4_BID(S4_BID), .S4_BRESP(S4_BRESP), .S4_BVALID(S4_BVALID), .S4_BUSER(S4_BUSER),
    .S4_BREADY(S4_BREADY),
    .S4_ARID(S4_ARID), .S4_ARADDR(S4_ARADDR), .S4_ARLEN(S4_ARLEN), .S4_ARSIZE(S4_ARSIZE),
    .S4_ARBURST(S4_ARBURST), .S4_ARLOCK(S4_ARLOCK), .S4_ARCACHE(S4_ARCACHE), .S4_ARPROT(S4_ARPROT),
    .S4_ARQOS(S4_ARQOS), .S4_ARREGION(S4_ARREGION), .S4_ARUSER(S4_ARUSER), .S4_ARVALID(S4_ARVALID),
    .S4_ARREADY(S4_ARREADY),
    .S4_RID(S4_RID), .S4_RDATA(S4_RDATA), .S4_RRESP(S4_RRESP), .S4_RLAST(S4_RLAST),
    .S4_RVALID(S4_RVALID), .S4_RUSER(S4_RUSER), .S4_RREADY(S4_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    S4_AWID = id; S4_AWADDR = addr; S4_AWLEN = len; S4_AWSIZE = size; S4_AWBURST = burst;
    S4_AWUSER = 1'b1; S4_AWVALID = 1'b1;
    while (!S4_AWREADY && n < 50) begin tick(); n++; end
    if (!S4_AWREADY) timeout("aw");
    tick();
    S4_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    S4_WDATA = data; S4_WSTRB = strb; S4_WLAST = last; S4_WVALID = 1'b1;
    while (!S4_WREADY && n < 50) begin tick(); n++; end
    if (!S4_WREADY) timeout("w");
    tick();
    S4_WVALID = 1'b0;
  endtask

  task automatic recv_b(output logic [3:0] id, output logic [1:0] resp, output logic user);
    int n = 0;
    S4_BREADY = 1'b1;
    while (!S4_BVALID && n < 50) begin tick(); n++; end
    if (!S4_BVALID) timeout("b");
    id = S4_BID; resp = S4_BRESP; user = S4_BUSER;
    tick();
    S4_BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    S4_ARID = id; S4_ARADDR = addr; S4_ARLEN = len; S4_ARSIZE = size; S4_ARBURST = burst;
    S4_ARUSER = 1'b1; S4_ARVALID = 1'b1;
    while (!S4_ARREADY && n < 50) begin tick(); n++; end
    if (!S4_ARREADY) timeout("ar");
    tick();
    S4_ARVALID = 1'b0;
  endtask

  task automatic recv_r(output logic [3:0] id, output logic [31:0] data, output logic [1:0] resp,
                        output logic last, output logic user);
    int n = 0;
    S4_RREADY = 1'b1;
    while (!S4_RVALID && n < 50) begin tick(); n++; end
    if (!S4_RVALID) timeout("r");
    id = S4_RID; data = S4_RDATA; resp = S4_RRESP; last = S4_RLAST; user = S4_RUSER;
    tick();
    S4_RREADY = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic        buser, ruser, rlast;
    logic [31:0] rdata;
    logic [31:0] exp4[4];
    int beat, cyc;

    //          wr    id     addr          sz    burst  data          strb   exp_data      resp
    vecs[0]  = '{1'b1, 4'd3,  32'h0000_0010, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 4'd5,  32'h0000_0010, 3'd2, 2'b01, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 4'd1,  32'h0000_0020, 3'd2, 2'b01, 32'h11223344, 4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 4'd2,  32'h0000_0020, 3'd2, 2'b01, 32'hFFFFFFFF, 4'h3, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 4'd6,  32'h0000_0020, 3'd2, 2'b01, 32'h0,        4'h0, 32'h1122FFFF, 2'b00};
    vecs[5]  = '{1'b1, 4'd4,  32'h0000_0000, 3'd2, 2'b01, 32'h0BADC0DE, 4'hF, 32'h0,        2'b00};
    vecs[6]  = '{1'b1, 4'd7,  32'h0000_0400, 3'd2, 2'b01, 32'hCAFEF00D, 4'hF, 32'h0,        2'b10};
    vecs[7]  = '{1'b0, 4'd8,  32'h0000_0000, 3'd2, 2'b01, 32'h0,        4'h0, 32'h0BADC0DE, 2'b00};
    vecs[8]  = '{1'b0, 4'd9,  32'h0000_0400, 3'd2, 2'b01, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[9]  = '{1'b1, 4'd10, 32'h0000_0024, 3'd3, 2'b01, 32'h55555555, 4'hF, 32'h0,        2'b10};
    vecs[10] = '{1'b0, 4'd11, 32'h0000_0010, 3'd3, 2'b01, 32'h0,        4'h0, 32'hDEADBEEF, 2'b10};
    vecs[11] = '{1'b1, 4'd12, 32'h0000_0028, 3'd2, 2'b11, 32'h12345678, 4'hF, 32'h0,        2'b10};
    vecs[12] = '{1'b1, 4'd13, 32'h0000_002C, 3'd2, 2'b10, 32'h9ABCDEF0, 4'hF, 32'h0,        2'b10};
    vecs[13] = '{1'b1, 4'd14, 32'h0000_03FC, 3'd2, 2'b01, 32'h76543210, 4'hF, 32'h0,        2'b00};
    vecs[14] = '{1'b0, 4'd15, 32'h0000_03FC, 3'd2, 2'b01, 32'h0,        4'h0, 32'h76543210, 2'b00};

    S4_AWID = '0; S4_AWADDR = '0; S4_AWLEN = '0; S4_AWSIZE = '0; S4_AWBURST = '0; S4_AWLOCK = 1'b0;
    S4_AWCACHE = '0; S4_AWPROT = '0; S4_AWQOS = '0; S4_AWREGION = '0; S4_AWUSER = 1'b0; S4_AWVALID = 1'b0;
    S4_WDATA = '0; S4_WSTRB = '0; S4_WLAST = 1'b0; S4_WUSER = 1'b0; S4_WVALID = 1'b0; S4_BREADY = 1'b0;
    S4_ARID = '0; S4_ARADDR = '0; S4_ARLEN = '0; S4_ARSIZE = '0; S4_ARBURST = '0; S4_ARLOCK = 1'b0;
    S4_ARCACHE = '0; S4_ARPROT = '0; S4_ARQOS = '0; S4_ARREGION = '0; S4_ARUSER = 1'b0; S4_ARVALID = 1'b0;
    S4_RREADY = 1'b0;

    // Reset held for three edges: every output low.
    ARESET = 1'b1;
    repeat (3) tick();
    chk("rst_awready", S4_AWREADY, 0); chk("rst_arready", S4_ARREADY, 0);
    chk("rst_wready", S4_WREADY, 0);   chk("rst_bvalid", S4_BVALID, 0);
    chk("rst_rvalid", S4_RVALID, 0);   chk("rst_bid", S4_BID, 0);
    chk("rst_bresp", S4_BRESP, 0);     chk("rst_rid", S4_RID, 0);
    chk("rst_rdata", S4_RDATA, 0);     chk("rst_rresp", S4_RRESP, 0);
    chk("rst_rlast", S4_RLAST, 0);     chk("rst_buser", S4_BUSER, 0);
    chk("rst_ruser", S4_RUSER, 0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_awready", S4_AWREADY, 1);
    chk("post_rst_arready", S4_ARREADY, 1);

    // Single-beat table.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        send_aw(vecs[i].id, vecs[i].addr, 4'd0, vecs[i].size, vecs[i].burst);
        send_w(vecs[i].data, vecs[i].strb, 1'b1);
        recv_b(bid, bresp, buser);
        chk($sformatf("vec%0d_bid", i), bid, vecs[i].id);
        chk($sformatf("vec%0d_bresp", i), bresp, vecs[i].exp_resp);
        chk($sformatf("vec%0d_buser", i), buser, EXP_USER);
      end else begin
        send_ar(vecs[i].id, vecs[i].addr, 4'd0, vecs[i].size, vecs[i].burst);
        recv_r(rid, rdata, rresp, rlast, ruser);
        chk($sformatf("vec%0d_rid", i), rid, vecs[i].id);
        chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), rresp, vecs[i].exp_resp);
        chk($sformatf("vec%0d_rlast", i), rlast, 1);
        chk($sformatf("vec%0d_ruser", i), ruser, EXP_USER);
      end
    end

    // 4-beat INCR write at 0x40, then read back with RREADY toggling every cycle.
    send_aw(4'd2, 32'h40, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      exp4[i] = 32'hA5A5_0000 + 32'(i);
      send_w(exp4[i], 4'hF, i == 3);
    end
    recv_b(bid, bresp, buser);
    chk("incr_bid", bid, 2);
    chk("incr_bresp", bresp, 0);
    send_ar(4'd9, 32'h40, 4'd3, 3'd2, 2'b01);
    beat = 0;
    cyc = 0;
    while (beat < 4 && cyc < 40) begin
      if (S4_RVALID) begin
        chk($sformatf("bp_c%0d_rdata", cyc), S4_RDATA, exp4[beat]);
        chk($sformatf("bp_c%0d_rlast", cyc), S4_RLAST, beat == 3);
        chk($sformatf("bp_c%0d_rid", cyc), S4_RID, 9);
        if (cyc % 2 == 1) beat++;
      end
      S4_RREADY = (cyc % 2 == 1);
      tick();
      cyc++;
    end
    S4_RREADY = 1'b0;
    if (beat != 4) timeout("bp_beats");
    chk("bp_rvalid_done", S4_RVALID, 0);
    chk("bp_arready_done", S4_ARREADY, 1);

    // Fill 0x30..0x3C, then a 4-beat WRAP read starting at 0x3C.
    send_aw(4'd1, 32'h30, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hC0DE_0030 + 32'(4 * i), 4'hF, i == 3);
    recv_b(bid, bresp, buser);
    chk("wrapfill_bresp", bresp, 0);
    exp4[0] = 32'hC0DE_003C; exp4[1] = 32'hC0DE_0030; exp4[2] = 32'hC0DE_0034; exp4[3] = 32'hC0DE_0038;
    send_ar(4'd4, 32'h3C, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      recv_r(rid, rdata, rresp, rlast, ruser);
      chk($sformatf("wrap_b%0d_rdata", i), rdata, exp4[i]);
      chk($sformatf("wrap_b%0d_rlast", i), rlast, i == 3);
      chk($sformatf("wrap_b%0d_rresp", i), rresp, 0);
    end

    // WLAST early on beat 2 of a 4-beat burst: burst closes, SLVERR.
    send_aw(4'd6, 32'h80, 4'd3, 3'd2, 2'b01);
    send_w(32'h1, 4'hF, 1'b0);
    send_w(32'h2, 4'hF, 1'b1);
    chk("early_wlast_wready", S4_WREADY, 0);
    recv_b(bid, bresp, buser);
    chk("early_wlast_bid", bid, 6);
    chk("early_wlast_bresp", bresp, 2'b10);

    // WLAST never asserted on a 2-beat burst: closes after beat 2, SLVERR.
    send_aw(4'd7, 32'h70, 4'd1, 3'd2, 2'b01);
    send_w(32'h3, 4'hF, 1'b0);
    send_w(32'h4, 4'hF, 1'b0);
    chk("no_wlast_wready", S4_WREADY, 0);
    recv_b(bid, bresp, buser);
    chk("no_wlast_bresp", bresp, 2'b10);

    // Reset in the middle of a write burst abandons it.
    send_aw(4'd8, 32'h60, 4'd3, 3'd2, 2'b01);
    send_w(32'h5, 4'hF, 1'b0);
    ARESET = 1'b1;
    tick();
    chk("midrst_wready", S4_WREADY, 0);
    chk("midrst_bvalid", S4_BVALID, 0);
    chk("midrst_awready", S4_AWREADY, 0);
    ARESET = 1'b0;
    tick();
    chk("midrst_awready_after", S4_AWREADY, 1);
    chk("midrst_wready_after", S4_WREADY, 0);

    // RAM survives reset.
    send_ar(4'd3, 32'h10, 4'd0, 3'd2, 2'b01);
    recv_r(rid, rdata, rresp, rlast, ruser);
    chk("ram_retained_rdata", rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
